// File: rtl/scaled_double_buffer_renderer.sv
// rtl/scaled_double_buffer_renderer.sv - double-buffered, integer-upscaled frame store between pixel producer and video output
//
// Purpose: accepts render-resolution pixels over valid/ready into the back
// buffer, scans the front buffer out at display resolution with SCALE-fold
// pixel replication, and swaps buffers at the start of vertical blanking.
// Ports:
//   clk_pixel_in, rst_in            pixel clock, synchronous active-high reset
//   hcount_in, vcount_in            display raster position
//   pix_valid_in, pix_data_in       producer pixel {R,G,B}, COLOR_BITS each
//   pix_ready_out                   renderer can accept a pixel
//   pix_x_out, pix_y_out            render coordinate of the next accepted pixel
//   freeze_in                       hold the displayed frame (inhibit swap)
//   test_mode_in                    0 store, 1 black, 2 colour bars, 3 store + border
//   frame_done_out, swap_out        single-cycle event pulses
//   red_out, green_out, blue_out    display colour, 2 cycles after hcount/vcount
module scaled_double_buffer_renderer #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int SCALE      = 4,
    parameter int COLOR_BITS = 8,
    localparam int RW = H_ACTIVE / SCALE,
    localparam int RH = V_ACTIVE / SCALE,
    localparam int XW = (RW > 1) ? $clog2(RW) : 1,
    localparam int YW = (RH > 1) ? $clog2(RH) : 1
) (
    input  logic                    clk_pixel_in,
    input  logic                    rst_in,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic                    pix_valid_in,
    input  logic [3*COLOR_BITS-1:0] pix_data_in,
    output logic                    pix_ready_out,
    output logic [XW-1:0]           pix_x_out,
    output logic [YW-1:0]           pix_y_out,
    input  logic                    freeze_in,
    input  logic [1:0]              test_mode_in,
    output logic                    frame_done_out,
    output logic                    swap_out,
    output logic [7:0]              red_out,
    output logic [7:0]              green_out,
    output logic [7:0]              blue_out
);
    localparam int SH    = (SCALE > 1) ? $clog2(SCALE) : 0;
    localparam int FRAME = RW * RH;
    localparam int DEPTH = 2 * FRAME;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 3 * COLOR_BITS;
    localparam int REPS  = (8 + COLOR_BITS - 1) / COLOR_BITS;
    localparam logic [XW-1:0] X_LAST = XW'(RW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(RH - 1);

    typedef enum logic {RENDER, WAIT_SWAP} state_t;

    state_t        state, state_next;
    logic          wbuf, rbuf, shown_valid;
    logic          accept, last_pixel, swap_event;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data;

    // Stage-1 copies of the per-pixel selection inputs, aligned with rd_data.
    logic       in_frame_q, border_q, shown_q;
    logic [1:0] mode_q;
    logic [2:0] bar_q;

    logic       in_frame, border;
    logic [2:0] bar;
    logic [10:0] hs;
    logic [9:0]  vs;
    logic [13:0] bar_num;
    logic [7:0]  red_next, green_next, blue_next;

    // Replicate the stored MSBs downward so full-scale stays full-scale.
    function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] v);
        logic [REPS*COLOR_BITS-1:0] rep;
        rep = {REPS{v}};
        return rep[REPS*COLOR_BITS-1 -: 8];
    endfunction

    always_comb begin
        pix_ready_out  = (state == RENDER);
        accept         = pix_valid_in && pix_ready_out;
        last_pixel     = (pix_x_out == X_LAST) && (pix_y_out == Y_LAST);
        swap_event     = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));
        state_next     = state;
        frame_done_out = 1'b0;
        swap_out       = 1'b0;
        case (state)
            RENDER: begin
                if (accept && last_pixel) begin
                    frame_done_out = 1'b1;
                    state_next     = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (swap_event && !freeze_in) begin
                    swap_out   = 1'b1;
                    state_next = RENDER;
                end
            end
            default: state_next = RENDER;
        endcase
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state       <= RENDER;
            pix_x_out   <= '0;
            pix_y_out   <= '0;
            wbuf        <= 1'b0;
            rbuf        <= 1'b1;
            shown_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (pix_x_out == X_LAST) begin
                    pix_x_out <= '0;
                    pix_y_out <= last_pixel ? '0 : pix_y_out + 1'b1;
                end else begin
                    pix_x_out <= pix_x_out + 1'b1;
                end
            end
            if (swap_out) begin
                wbuf        <= ~wbuf;
                rbuf        <= ~rbuf;
                shown_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        hs       = hcount_in >> SH;
        vs       = vcount_in >> SH;
        in_frame = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
        border   = (hcount_in == 11'd0) || (hcount_in == 11'(H_ACTIVE - 1)) ||
                   (vcount_in == 10'd0) || (vcount_in == 10'(V_ACTIVE - 1));
        bar_num  = {hcount_in, 3'b000};
        bar      = 3'(bar_num / 14'(H_ACTIVE));
        wr_addr  = (wbuf ? AW'(FRAME) : '0) + AW'(pix_y_out) * AW'(RW) + AW'(pix_x_out);
        // Blanking reads are parked at address 0 so they never leave the array.
        rd_addr  = in_frame ? (rbuf ? AW'(FRAME) : '0) + AW'(vs) * AW'(RW) + AW'(hs) : '0;
    end

    always_ff @(posedge clk_pixel_in) begin
        if (accept) begin
            mem[wr_addr] <= pix_data_in;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            in_frame_q <= 1'b0;
            border_q   <= 1'b0;
            shown_q    <= 1'b0;
            mode_q     <= 2'd0;
            bar_q      <= 3'd0;
        end else begin
            in_frame_q <= in_frame;
            border_q   <= border;
            shown_q    <= shown_valid;
            mode_q     <= test_mode_in;
            bar_q      <= bar;
        end
    end

    always_comb begin
        red_next   = 8'd0;
        green_next = 8'd0;
        blue_next  = 8'd0;
        if (in_frame_q) begin
            case (mode_q)
                2'd2: begin
                    // Bar order white..black falls out of the index bits directly.
                    red_next   = {8{~bar_q[1]}};
                    green_next = {8{~bar_q[2]}};
                    blue_next  = {8{~bar_q[0]}};
                end
                2'd0, 2'd3: begin
                    if (shown_q) begin
                        if (mode_q == 2'd3 && border_q) begin
                            red_next   = 8'hFF;
                            green_next = 8'hFF;
                            blue_next  = 8'hFF;
                        end else begin
                            red_next   = expand(rd_data[DW-1 -: COLOR_BITS]);
                            green_next = expand(rd_data[2*COLOR_BITS-1 -: COLOR_BITS]);
                            blue_next  = expand(rd_data[COLOR_BITS-1:0]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
        end else begin
            red_out   <= red_next;
            green_out <= green_next;
            blue_out  <= blue_next;
        end
    end
endmodule

// File: tb/tb_scaled_double_buffer_renderer.sv
// tb/tb_scaled_double_buffer_renderer.sv - self-checking bench for scaled_double_buffer_renderer
module tb_scaled_double_buffer_renderer;
    localparam int H = 16;
    localparam int V = 8;
    localparam int H_TOT = 20;
    localparam int V_TOT = 10;
    localparam int NPIX = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hc = '0;
    logic [9:0]  vc = '0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        freeze = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        pix_ready, frame_done, swap;
    logic [2:0]  pix_x;
    logic [1:0]  pix_y;
    logic [7:0]  r, g, b;

    logic [11:0] pix_data4 = 12'hA53;
    logic        ready4, fd4, sw4;
    logic [2:0]  x4;
    logic [1:0]  y4;
    logic [7:0]  r4, g4, b4;

    int hcnt = 0, vcnt = 0;
    int checks = 0, errors = 0;
    int fd_cnt = 0, sw_cnt = 0;

    always #5 clk = ~clk;

    scaled_double_buffer_renderer #(.H_ACTIVE(H), .V_ACTIVE(V), .SCALE(2), .COLOR_BITS(8)) dut (
        .clk_pixel_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
        .pix_valid_in(pix_valid), .pix_data_in(pix_data), .pix_ready_out(pix_ready),
        .pix_x_out(pix_x), .pix_y_out(pix_y), .freeze_in(freeze), .test_mode_in(mode),
        .frame_done_out(frame_done), .swap_out(swap),
        .red_out(r), .green_out(g), .blue_out(b));

    scaled_double_buffer_renderer #(.H_ACTIVE(H), .V_ACTIVE(V), .SCALE(2), .COLOR_BITS(4)) dut4 (
        .clk_pixel_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
        .pix_valid_in(pix_valid), .pix_data_in(pix_data4), .pix_ready_out(ready4),
        .pix_x_out(x4), .pix_y_out(y4), .freeze_in(freeze), .test_mode_in(mode),
        .frame_done_out(fd4), .swap_out(sw4),
        .red_out(r4), .green_out(g4), .blue_out(b4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: two frame arrays, a pixel counter and swap bookkeeping.
    logic [23:0] mbuf [2][NPIX];
    int          n = 0;
    bit          waiting = 0, mw = 0, mr = 1, shown = 0, mvalid = 0;
    logic [23:0] q [$];
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] model_colour();
        if (hcnt >= H || vcnt >= V) return 24'h0;
        if (mode == 2'd1) return 24'h0;
        if (mode == 2'd2) return bar_tab[hcnt * 8 / H];
        if (!shown) return 24'h0;
        if (mode == 2'd3 && (hcnt == 0 || hcnt == H - 1 || vcnt == 0 || vcnt == V - 1))
            return 24'hFFFFFF;
        return mbuf[mr][(vcnt / 2) * 8 + hcnt / 2];
    endfunction

    always @(negedge clk) begin
        bit exp_ready, acc, exp_fd, exp_sw;
        logic [23:0] exp_col;
        if (rst) begin
            n = 0; waiting = 0; mw = 0; mr = 1; shown = 0; mvalid = 1;
            q.delete();
            q.push_back(24'h0);
            q.push_back(24'h0);
        end else if (mvalid) begin
            exp_ready = !waiting;
            acc       = pix_valid && exp_ready;
            exp_fd    = acc && (n == NPIX - 1);
            exp_sw    = waiting && hcnt == 0 && vcnt == V && !freeze;
            check("ready", 32'(pix_ready), 32'(exp_ready));
            check("pix_x", 32'(pix_x), 32'(n % 8));
            check("pix_y", 32'(pix_y), 32'(n / 8));
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            check("swap", 32'(swap), 32'(exp_sw));
            check("dut4_handshake", {24'h0, ready4, x4, y4, fd4, sw4},
                  {24'h0, exp_ready, 3'(n % 8), 2'(n / 8), exp_fd, exp_sw});
            exp_col = q.pop_front();
            check("colour", {8'h0, r, g, b}, {8'h0, exp_col});
            q.push_back(model_colour());
            if (frame_done) fd_cnt++;
            if (swap) sw_cnt++;
            if (acc) begin
                mbuf[mw][n] = pix_data;
                if (n == NPIX - 1) begin
                    n = 0;
                    waiting = 1;
                end else begin
                    n++;
                end
            end
            if (exp_sw) begin
                mw = !mw; mr = !mr; shown = 1; waiting = 0;
            end
        end
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
        hcnt++;
        if (hcnt == H_TOT) begin
            hcnt = 0;
            vcnt = (vcnt + 1) % V_TOT;
        end
        hc = 11'(hcnt);
        vc = 10'(vcnt);
    endtask

    task automatic wait_raster(input int th, input int tv);
        int budget = 0;
        while (!(hcnt == th && vcnt == tv) && budget < 500) begin
            clk_step();
            budget++;
        end
        check("raster_reached", 32'(budget < 500), 32'd1);
    endtask

    // rand_valid: toggle valid randomly; rand_data: random pixels, else {i,i,i}.
    task automatic send_frame(input bit rand_valid, input bit rand_data, input int cnt);
        int sent = 0, budget = 0;
        bit acc;
        while (sent < cnt && budget < 2000) begin
            pix_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = rand_data ? 24'($urandom) : {3{8'(sent)}};
            @(negedge clk);
            acc = pix_valid && pix_ready;
            clk_step();
            if (acc) sent++;
            budget++;
        end
        pix_valid = 1'b0;
        check("send_budget", 32'(budget < 2000), 32'd1);
    endtask

    task automatic colour_at(input string name, input int th, input int tv, input logic [23:0] exp);
        wait_raster(th, tv);
        clk_step();
        clk_step();
        @(negedge clk);
        check(name, {8'h0, r, g, b}, {8'h0, exp});
    endtask

    initial begin
        int sw0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NPIX; i++) mbuf[k][i] = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ready", 32'(pix_ready), 32'd1);
        check("reset_xy", {27'h0, pix_x, pix_y}, 32'h0);
        check("reset_colour", {8'h0, r, g, b}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame 1: data = index, valid held high.
        send_frame(1'b0, 1'b0, NPIX);
        check("fd_after_frame1", 32'(fd_cnt), 32'd1);
        check("no_swap_yet", 32'(sw_cnt), 32'd0);
        wait_raster(0, V);
        clk_step();
        check("first_swap", 32'(sw_cnt), 32'd1);
        colour_at("pixel_5_3", 5, 3, 24'h0A0A0A);
        check("dut4_expand", {8'h0, r4, g4, b4}, 32'hAA5533);
        check("ready_after_swap", 32'(pix_ready), 32'd1);

        // Frame 2 with random valid and data, then freeze across two blanks.
        send_frame(1'b1, 1'b1, NPIX);
        freeze = 1'b1;
        sw0 = sw_cnt;
        repeat (2 * H_TOT * V_TOT) clk_step();
        check("freeze_no_swap", 32'(sw_cnt), 32'(sw0));
        check("freeze_ready", 32'(pix_ready), 32'd0);
        colour_at("frozen_frame", 5, 3, 24'h0A0A0A);
        freeze = 1'b0;
        wait_raster(0, V);
        clk_step();
        check("swap_after_release", 32'(sw_cnt), 32'(sw0 + 1));
        repeat (H_TOT * V_TOT) clk_step();

        // Frame 3: last accept lands exactly on the swap-event cycle.
        wait_raster(9, 6);
        sw0 = sw_cnt;
        send_frame(1'b0, 1'b1, NPIX);
        repeat (H_TOT * V_TOT - 2) clk_step();
        check("coincide_no_swap", 32'(sw_cnt), 32'(sw0));
        wait_raster(0, V);
        clk_step();
        check("coincide_next_swap", 32'(sw_cnt), 32'(sw0 + 1));

        // Test patterns.
        mode = 2'd2;
        colour_at("bars_h1", 1, 2, 24'hFFFFFF);
        colour_at("bars_h14", 14, 2, 24'h000000);
        repeat (H_TOT * V_TOT) clk_step();
        mode = 2'd3;
        colour_at("border_0_0", 0, 0, 24'hFFFFFF);
        repeat (H_TOT * V_TOT) clk_step();
        mode = 2'd1;
        repeat (H_TOT * V_TOT) clk_step();
        mode = 2'd0;

        // Reset mid-stream.
        send_frame(1'b0, 1'b1, 10);
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_xy", {27'h0, pix_x, pix_y}, 32'h0);
        check("rst_ready", 32'(pix_ready), 32'd1);
        sw0 = fd_cnt;
        send_frame(1'b1, 1'b1, NPIX);
        check("fd_after_reset", 32'(fd_cnt), 32'(sw0 + 1));
        repeat (2 * H_TOT * V_TOT) clk_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
